// File: rtl/poker_pkg.sv
// Shared constants and types for the poker round dealer.
// Contents: card geometry, deck size, LFSR seed/taps, card_t payload,
// the round FSM state enum and a card-to-deck-index helper.
package poker_pkg;

    localparam int unsigned CARD_W     = 6;
    localparam int unsigned RANK_COUNT = 13;
    localparam int unsigned DECK_SIZE  = 52;
    localparam int unsigned LFSR_W     = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Galois right-shift feedback mask for x^16+x^14+x^13+x^11+1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;   // 0..12 = 2..A
    } card_t;

    typedef enum logic [1:0] {IDLE, DRAW, EVAL, DONE} state_t;

    // Dense 0..51 position of a legal card in the used-card bitmap
    function automatic logic [5:0] deck_index(input card_t c);
        return 6'(6'(c.suit) * 6'(RANK_COUNT) + 6'(c.rank));
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// 16-bit Galois LFSR supplying candidate cards to the dealer.
// Ports: clk, rst (sync active-low), load (take seed), advance (step once),
//        seed (16b, 0 substituted by LFSR_SEED), cand (low 6 bits = candidate).
module card_lfsr
    import poker_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [LFSR_W-1:0] seed,
    output logic [CARD_W-1:0] cand
);

    logic [LFSR_W-1:0] lfsr_q;

    // Load wins over advance; an all-zero seed would lock the register up
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (load) begin
            lfsr_q <= (seed == '0) ? LFSR_SEED : seed;
        end else if (advance) begin
            lfsr_q <= {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        end
    end

    assign cand = lfsr_q[CARD_W-1:0];

endmodule

// File: rtl/poker_round_dealer.sv
// Runs one poker round for NUM_PLAYERS players: deals unique cards by LFSR
// rejection sampling, asks the external evaluator for each hand score and
// reports the winner.
// Ports: clk, rst (sync active-low), seed_load/seed_in, start, busy,
//        cards/cards_valid, eval_req/eval_player/eval_ack/eval_score,
//        winner_idx/tie/winner_valid.
// Build option: define POKER_BURN_CARD_EN to burn one card before the flop,
// turn and river.
module poker_round_dealer
    import poker_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned SCORE_W     = 20
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              seed_load,
    input  logic [15:0]                       seed_in,
    input  logic                              start,
    output logic                              busy,
    output logic [6*(2*NUM_PLAYERS+5)-1:0]    cards,
    output logic                              cards_valid,
    output logic                              eval_req,
    output logic [2:0]                        eval_player,
    input  logic                              eval_ack,
    input  logic [SCORE_W-1:0]                eval_score,
    output logic [2:0]                        winner_idx,
    output logic                              tie,
    output logic                              winner_valid
);

    localparam int unsigned NUM_CARDS = 2 * NUM_PLAYERS + 5;
    localparam int unsigned CARDS_W   = CARD_W * NUM_CARDS;
`ifdef POKER_BURN_CARD_EN
    localparam int unsigned NUM_STEPS = NUM_CARDS + 3;
`else
    localparam int unsigned NUM_STEPS = NUM_CARDS;
`endif
    localparam logic [4:0] NP   = 5'(NUM_PLAYERS);
    localparam logic [4:0] NP2  = 5'(2 * NUM_PLAYERS);
    localparam logic [4:0] LAST = 5'(NUM_STEPS - 1);

    state_t               state, state_d;
    logic                 busy_d, cards_valid_d, eval_req_d, tie_d, winner_valid_d;
    logic [CARDS_W-1:0]   cards_d;
    logic [2:0]           eval_player_d, winner_idx_d;
    logic [DECK_SIZE-1:0] used, used_d;
    logic [4:0]           step, step_d;
    logic [SCORE_W-1:0]   best, best_d;

    logic [CARD_W-1:0]    cand_raw;
    card_t                cand;
    logic [5:0]           cand_idx;
    logic                 cand_ok;
    logic [5:0]           target;
    logic                 lfsr_load, lfsr_advance;

    assign lfsr_load    = seed_load && (state == IDLE);
    assign lfsr_advance = (state == DRAW);

    card_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .advance (lfsr_advance),
        .seed    (seed_in),
        .cand    (cand_raw)
    );

    // Deal step -> {burn, slot}: player first cards, player second cards, then board
    function automatic logic [5:0] step_target(input logic [4:0] s);
        if (s < NP)
            return {1'b0, 5'(s << 1)};
        else if (s < NP2)
            return {1'b0, 5'(((s - NP) << 1) + 5'd1)};
`ifdef POKER_BURN_CARD_EN
        else if (s == NP2 || s == NP2 + 5'd4 || s == NP2 + 5'd6)
            return {1'b1, 5'd0};
        else if (s <= NP2 + 5'd3)
            return {1'b0, s - 5'd1};
        else if (s == NP2 + 5'd5)
            return {1'b0, s - 5'd2};
        else
            return {1'b0, s - 5'd3};
`else
        else
            return {1'b0, s};
`endif
    endfunction

    assign cand     = card_t'(cand_raw);
    assign cand_idx = deck_index(cand);
    assign cand_ok  = (cand.rank < 4'(RANK_COUNT)) && !used[cand_idx];
    assign target   = step_target(step);

    // Next-state and next-output logic
    always_comb begin
        state_d        = state;
        busy_d         = busy;
        cards_d        = cards;
        cards_valid_d  = cards_valid;
        eval_req_d     = eval_req;
        eval_player_d  = eval_player;
        winner_idx_d   = winner_idx;
        tie_d          = tie;
        winner_valid_d = winner_valid;
        used_d         = used;
        step_d         = step;
        best_d         = best;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d        = DRAW;
                    busy_d         = 1'b1;
                    cards_d        = '0;
                    cards_valid_d  = 1'b0;
                    winner_valid_d = 1'b0;
                    tie_d          = 1'b0;
                    used_d         = '0;
                    step_d         = '0;
                    eval_player_d  = '0;
                end
            end
            DRAW: begin
                if (cand_ok) begin
                    used_d[cand_idx] = 1'b1;
                    if (!target[5])
                        cards_d[CARD_W*int'(target[4:0]) +: CARD_W] = cand;
                    if (step == LAST) begin
                        state_d       = EVAL;
                        cards_valid_d = 1'b1;
                    end else begin
                        step_d = step + 5'd1;
                    end
                end
            end
            EVAL: begin
                // A low eval_req here is the mandatory idle cycle before a request
                if (!eval_req) begin
                    eval_req_d = 1'b1;
                end else if (eval_ack) begin
                    eval_req_d = 1'b0;
                    if (eval_player == 3'd0 || eval_score > best) begin
                        best_d       = eval_score;
                        winner_idx_d = eval_player;
                        tie_d        = 1'b0;
                    end else if (eval_score == best) begin
                        tie_d = 1'b1;
                    end
                    if (eval_player == 3'(NUM_PLAYERS - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                    end else begin
                        eval_player_d = eval_player + 3'd1;
                    end
                end
            end
            DONE: begin
                winner_valid_d = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            cards        <= '0;
            cards_valid  <= 1'b0;
            eval_req     <= 1'b0;
            eval_player  <= '0;
            winner_idx   <= '0;
            tie          <= 1'b0;
            winner_valid <= 1'b0;
            used         <= '0;
            step         <= '0;
            best         <= '0;
        end else begin
            state        <= state_d;
            busy         <= busy_d;
            cards        <= cards_d;
            cards_valid  <= cards_valid_d;
            eval_req     <= eval_req_d;
            eval_player  <= eval_player_d;
            winner_idx   <= winner_idx_d;
            tie          <= tie_d;
            winner_valid <= winner_valid_d;
            used         <= used_d;
            step         <= step_d;
            best         <= best_d;
        end
    end

endmodule

// File: tb/tb_poker_round_dealer.sv
// Self-checking bench for poker_round_dealer (4 players) with a deck/score
// model kept at card-list level.
module tb_poker_round_dealer;

    localparam int unsigned N  = 4;
    localparam int unsigned SW = 20;
    localparam int unsigned NC = 2 * N + 5;

    logic          clk = 1'b0;
    logic          rst, seed_load, start, eval_ack;
    logic [15:0]   seed_in;
    logic [SW-1:0] eval_score;
    logic          busy, cards_valid, eval_req, tie, winner_valid;
    logic [6*NC-1:0] cards;
    logic [2:0]    eval_player, winner_idx;

    always #5 clk = ~clk;

    poker_round_dealer #(.NUM_PLAYERS(N), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .start(start), .busy(busy), .cards(cards), .cards_valid(cards_valid),
        .eval_req(eval_req), .eval_player(eval_player), .eval_ack(eval_ack),
        .eval_score(eval_score), .winner_idx(winner_idx), .tie(tie),
        .winner_valid(winner_valid)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    logic [5:0]  exp_cards [NC];
    int          exp_draws;
    int          slot_order[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Multiply-by-x step of x^16+x^14+x^13+x^11+1, right-shift Galois form
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Which slot each accepted card lands in; -1 marks a burn
    task automatic build_order();
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < int'(N); p++) slot_order.push_back(2 * p + c);
`ifdef POKER_BURN_CARD_EN
        slot_order.push_back(-1);
`endif
        for (int k = 0; k < 3; k++) slot_order.push_back(2 * N + k);
`ifdef POKER_BURN_CARD_EN
        slot_order.push_back(-1);
`endif
        slot_order.push_back(2 * N + 3);
`ifdef POKER_BURN_CARD_EN
        slot_order.push_back(-1);
`endif
        slot_order.push_back(2 * N + 4);
    endtask

    // Draws from m_lfsr until every slot (and burn) is filled
    task automatic model_deal();
        bit used [64];
        int taken;
        logic [5:0] c;
        foreach (used[i]) used[i] = 1'b0;
        taken = 0;
        exp_draws = 0;
        while (taken < slot_order.size() && exp_draws < 100000) begin
            c = m_lfsr[5:0];
            exp_draws++;
            if (c[3:0] < 4'd13 && !used[c]) begin
                used[c] = 1'b1;
                if (slot_order[taken] >= 0) exp_cards[slot_order[taken]] = c;
                taken++;
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_cards"}, (cards == '0), 1);
        check({name, "_cards_valid"}, cards_valid, 0);
        check({name, "_eval_req"}, eval_req, 0);
        check({name, "_eval_player"}, eval_player, 0);
        check({name, "_winner_idx"}, winner_idx, 0);
        check({name, "_tie"}, tie, 0);
        check({name, "_winner_valid"}, winner_valid, 0);
    endtask

    // mode 0: seed_load with start; 1: seed_load the cycle before; 2: keep LFSR running
    task automatic run_round(input int mode, input logic [15:0] seed,
                             input logic [SW-1:0] sc [N], input int dly [N]);
        logic [SW-1:0] best;
        int w, nbest, dups;
        bit seen [64];
        logic [5:0] cv;

        best = sc[0];
        w = 0;
        for (int p = 1; p < int'(N); p++) if (sc[p] > best) begin best = sc[p]; w = p; end
        nbest = 0;
        for (int p = 0; p < int'(N); p++) if (sc[p] == best) nbest++;

        if (mode == 1) begin
            seed_load = 1'b1; seed_in = seed;
            @(negedge clk);
            seed_load = 1'b0;
            check("idle_busy", busy, 0);
        end
        if (mode != 2) m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
        seed_load = (mode == 0); seed_in = seed; start = 1'b1;
        model_deal();
        @(negedge clk);
        start = 1'b0; seed_load = 1'b0;
        check("start_busy", busy, 1);
        check("start_cards_valid", cards_valid, 0);
        check("start_winner_valid", winner_valid, 0);
        check("start_tie", tie, 0);
        check("start_eval_req", eval_req, 0);

        for (int c = 1; c < exp_draws; c++) begin
            seed_load = 1'($urandom_range(0, 1)); seed_in = 16'($urandom);
            @(negedge clk);
            check("draw_busy", busy, 1);
            check("draw_cards_valid", cards_valid, 0);
            check("draw_eval_req", eval_req, 0);
        end
        seed_load = 1'b0;
        @(negedge clk);
        check("deal_cards_valid", cards_valid, 1);
        check("deal_eval_req", eval_req, 0);
        foreach (seen[i]) seen[i] = 1'b0;
        dups = 0;
        for (int k = 0; k < int'(NC); k++) begin
            cv = cards[6*k +: 6];
            check($sformatf("card_slot%0d", k), cv, exp_cards[k]);
            check("card_rank_legal", (cv[3:0] < 4'd13), 1);
            if (seen[cv]) dups++;
            seen[cv] = 1'b1;
        end
        check("card_duplicates", dups, 0);

        eval_ack = 1'b1; eval_score = SW'($urandom);     // ack with no request pending
        for (int p = 0; p < int'(N); p++) begin
            @(negedge clk);
            eval_ack = 1'b0;
            check("req_high", eval_req, 1);
            check("req_player", eval_player, p);
            check("req_busy", busy, 1);
            for (int i = 0; i < dly[p]; i++) begin
                start = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("wait_req", eval_req, 1);
                check("wait_player", eval_player, p);
            end
            start = 1'b0;
            eval_ack = 1'b1; eval_score = sc[p];
            @(negedge clk);
            check("gap_req", eval_req, 0);
            if (p < int'(N) - 1) eval_score = SW'($urandom);
            else eval_ack = 1'b0;
        end
        check("done_busy", busy, 0);
        @(negedge clk);
        check("res_winner_valid", winner_valid, 1);
        check("res_winner_idx", winner_idx, w);
        check("res_tie", tie, (nbest > 1));
        check("res_busy", busy, 0);
        check("res_cards_valid", cards_valid, 1);
    endtask

    task automatic abort_round(input logic [15:0] seed, input bit in_eval);
        m_lfsr = seed;
        seed_load = 1'b1; seed_in = seed; start = 1'b1;
        model_deal();
        @(negedge clk);
        seed_load = 1'b0; start = 1'b0;
        repeat (in_eval ? exp_draws + 1 : 3) @(negedge clk);
        if (in_eval) check("abort_eval_req", eval_req, 1);
        else check("abort_draw_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero(in_eval ? "abort_eval" : "abort_draw");
        rst = 1'b1;
        m_lfsr = 16'hACE1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [SW-1:0] sc [N];
        int dly [N];
        logic [15:0] sd;

        build_order();
        rst = 1'b0; seed_load = 1'b0; start = 1'b0; eval_ack = 1'b0;
        seed_in = '0; eval_score = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        m_lfsr = 16'hACE1;

        // Seed 0 falls back to ACE1: first candidates 0x21, 0x30, 0x38, 0x1C all accepted
        sc = '{20'd5, 20'd9, 20'd2, 20'd4};
        dly = '{0, 0, 0, 0};
        run_round(0, 16'h0000, sc, dly);
        check("pin_p0c0", cards[5:0], 6'h21);
        check("pin_p1c0", cards[17:12], 6'h30);
        check("pin_p2c0", cards[29:24], 6'h38);
        check("pin_p3c0", cards[41:36], 6'h1C);
        check("pin_win_5_9", winner_idx, 1);
        check("pin_tie_5_9", tie, 0);

        sc = '{20'd7, 20'd7, 20'd3, 20'd7};
        dly = '{0, 1, 20, 0};
        run_round(1, 16'h1234, sc, dly);
        check("pin_win_7737", winner_idx, 0);
        check("pin_tie_7737", tie, 1);

        sc = '{20'h7FFFF, 20'hFFFFF, 20'h80000, 20'hFFFFF};
        dly = '{2, 0, 1, 3};
        run_round(2, 16'h0000, sc, dly);
        check("pin_win_msb", winner_idx, 1);
        check("pin_tie_msb", tie, 1);

        sc = '{20'd1, 20'd2, 20'd3, 20'd4};
        dly = '{1, 1, 1, 1};
        abort_round(16'h5A5A, 1'b0);
        run_round(0, 16'h5A5A, sc, dly);
        abort_round(16'h0F0F, 1'b1);
        run_round(0, 16'h0F0F, sc, dly);
        check("pin_win_1234", winner_idx, 3);

        for (int r = 0; r < 200; r++) begin
            sd = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'($urandom);
            for (int p = 0; p < int'(N); p++) begin
                sc[p]  = ($urandom_range(0, 1) == 1) ? SW'($urandom_range(0, 3)) : SW'($urandom);
                dly[p] = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
            end
            run_round(int'($urandom_range(0, 2)), sd, sc, dly);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/poker_round_dealer.md
Name: poker_round_dealer

Overview:
- Parametrised successor to the two-player hold'em top: runs one full round for NUM_PLAYERS players.
- Deals unique cards from a single 52-card deck with no duplicates, using LFSR rejection sampling and a used-card bitmap.
- Sequences per-player hand evaluation through a req/ack handshake with the external evaluator chain (flush/straight/same-number/level logic).
- Reports the winning player index and a tie flag.

Parameters:
- NUM_PLAYERS, 2, players per round; legal range 2..8.
- SCORE_W, 20, width of the evaluator hand score; a larger score is a better hand.
- NUM_CARDS, 2*NUM_PLAYERS+5, derived (localparam); dealt slots, excluding burns.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- seed_load  in  1  loads seed_in into the LFSR; honoured in IDLE only.
- seed_in  in  16  LFSR seed; 0 is replaced by 16'hACE1.
- start  in  1  one-cycle pulse that begins a round; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until DONE is entered.
- cards  out  6*NUM_CARDS  dealt cards. Slot k is cards[6k+5:6k], encoded {suit[1:0], rank[3:0]}, rank 0..12 = 2..A. Slots 0..2N-1 are player cards (player p holds slots 2p and 2p+1); the last 5 slots are community cards.
- cards_valid  out  1  high once the deal is complete, until the next accepted start.
- eval_req  out  1  evaluation request, held until acknowledged.
- eval_player  out  3  player index under evaluation.
- eval_ack  in  1  evaluator acknowledge; eval_score is sampled in the same cycle.
- eval_score  in  SCORE_W  hand score of eval_player.
- winner_idx  out  3  index of the best player (lowest index among tied players).
- tie  out  1  another player equals the best score.
- winner_valid  out  1  result valid; held until the next accepted start.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; all outputs 0; used bitmap cleared; LFSR = 16'hACE1; deal index 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle in DRAW only. Candidate card = lfsr[5:0].
- IDLE:
  - seed_load=1 loads the seed.
  - start=1 clears the bitmap, cards, cards_valid, winner_valid and tie, then goes to DRAW.
  - If seed_load and start are both high in the same cycle, the seed loads first and the round uses the new seed.
- DRAW: one candidate per cycle.
  - Accept when rank<13 and the bitmap bit is clear. On accept: write the card to the current slot, set its bitmap bit, increment the slot.
  - Reject otherwise; no state change except the LFSR step.
  - Deal order: p0c0, p1c0, ..., p(N-1)c0, p0c1, ..., then community slots 0..4.
  - When the last slot is accepted: cards_valid=1 in the next cycle; go to EVAL.
  - Termination is guaranteed: at most 24 of 52 cards are consumed, and a maximal LFSR visits every 6-bit pattern.
- EVAL:
  - Drive eval_req=1 with eval_player=p, starting at p=0. eval_req stays high until a cycle with eval_ack=1.
  - Latency is unbounded; eval_ack while eval_req=0 is ignored.
  - On ack, player 0 becomes the best by definition. For later players: score>best updates best and winner_idx and clears tie; score==best sets tie=1; score<best changes nothing.
  - Acknowledging the last player sends the FSM to DONE.
  - eval_req drops in the cycle after the ack. It re-asserts for the next player one cycle later, so there is exactly one idle cycle between requests.
- DONE: winner_valid=1 and busy=0; go to IDLE in the same transition, so the result holds in IDLE.
- Score comparison is unsigned, full SCORE_W width.
- Reset mid-round: abort immediately, return to the reset values, and drop eval_req.

Optional Feature:
- Macro POKER_BURN_CARD_EN.
- Defined: one burn card is drawn, with normal accept rules, immediately before community slot 0 (flop), slot 3 (turn) and slot 4 (river). Burn cards set bitmap bits but are never written to cards or shown on any port. The deal takes three more accepts.
- Undefined: no burns; the deal order is as above.

Decomposition:
- Package poker_pkg holds:
  - constants CARD_W=6, RANK_COUNT=13, DECK_SIZE=52, LFSR_SEED=16'hACE1;
  - typedef card_t {suit, rank};
  - the state enum {IDLE, DRAW, EVAL, DONE}.
- Sub-module card_lfsr: 16-bit Galois LFSR with load, advance and zero-seed substitution. The FSM, bitmap and compare logic stay in poker_round_dealer.

Test Plan:
- Reset, then seed 16'h1234, N=2, start, evaluator acks instantly with scores {5,9} → all 9 cards distinct with rank<13; winner_idx=1, tie=0, winner_valid=1.
- N=8, 1000 rounds with random seeds → no duplicate card within any round and never rank>12; cards_valid precedes the first eval_req.
- N=4, scores {7,7,3,7} → winner_idx=0, tie=1.
- Evaluator holds off eval_ack for 0, 1 and 20 cycles → eval_req and eval_player stay stable while waiting; exactly 4 requests; one idle cycle between requests.
- rst=0 pulsed during DRAW, then during EVAL → all outputs 0 next cycle; a new start with the same seed reproduces the identical deal.
- With POKER_BURN_CARD_EN, seed 16'hACE1 → exactly 3 extra accepted draws; burn cards absent from cards; all 12 bitmap bits set (N=2).
